// File: rtl/sd_pkg.sv
// Shared definitions for the SD data-path blocks (block transmit and receive).
package sd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_STAT_WAIT,
        ST_STAT,
        ST_BUSY,
        ST_DONE
    } sd_state_e;

    localparam logic [15:0] CRC16_POLY     = 16'h1021;
    localparam logic [2:0]  STATUS_OK      = 3'b010;
    localparam logic [2:0]  STATUS_CRC_ERR = 3'b101;
    localparam logic [2:0]  STATUS_WR_ERR  = 3'b110;
    localparam int unsigned BLOCK_BITS     = 4096;

    // Byte 0 goes on the wire first, each byte MSB first: reorder so a plain MSB-first shift works.
    function automatic logic [31:0] tx_byte_order(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sd_crc16.sv
// Bit-serial CRC16 (x^16+x^12+x^5+1, init 0); shared by the SD transmit and receive paths.
module sd_crc16
    import sd_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb_c;

    always_comb begin
        fb_c  = bit_i ^ crc_q[15];
        crc_d = {crc_q[14:0], 1'b0} ^ (fb_c ? CRC16_POLY : 16'h0000);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= 16'h0000;
        end else if (clr_i) begin
            crc_q <= 16'h0000;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_block_tx.sv
// SD single-block write transmitter: buffer RAM -> DAT0 (1-bit mode), then CRC status and busy.
// Optional feature macro: SD_BLOCK_TX_CRC_STATUS_EN (card status token and busy wait).
module sd_block_tx
    import sd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned BLOCK_WORDS = 128
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            status,
    output logic                  status_err,
    output logic                  buf_ren,
    output logic [ADDR_WIDTH-1:0] buf_addr,
    input  logic [DATA_WIDTH-1:0] buf_rdata,
    output logic                  dat_out,
    output logic                  dat_oe,
    input  logic                  dat_in
);

    localparam int unsigned TX_BITS = BLOCK_WORDS * DATA_WIDTH;
    localparam int unsigned CNT_W   = $clog2(TX_BITS);
    localparam int unsigned RC_W    = $clog2(BLOCK_WORDS + 1);

    sd_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [RC_W-1:0]       rd_cnt_q;
    logic [31:0]           shift_q;
    logic [DATA_WIDTH-1:0] next_q;
    logic                  rd_vld_q;
    logic                  loaded_q;
    logic                  busy_q;
    logic                  done_q;
    logic [2:0]            status_q;
    logic                  status_err_q;
    logic                  buf_ren_q;
    logic [ADDR_WIDTH-1:0] buf_addr_q;
    logic                  dat_out_q;
    logic                  dat_oe_q;
`ifdef SD_BLOCK_TX_CRC_STATUS_EN
    logic [2:0]            stat_sr_q;
`else
    logic                  unused_dat_in;
    assign unused_dat_in = dat_in;
`endif

    logic        crc_en_c;
    logic        crc_clr_c;
    logic [15:0] crc_w;
    logic [3:0]  crc_idx_c;

    assign crc_en_c  = tick && !abort && (state_q == ST_DATA);
    assign crc_clr_c = (state_q == ST_IDLE);
    assign crc_idx_c = ~cnt_q[3:0];

    sd_crc16 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (crc_clr_c),
        .en_i    (crc_en_c),
        .bit_i   (shift_q[31]),
        .crc_o   (crc_w)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rd_cnt_q     <= '0;
            shift_q      <= '0;
            next_q       <= '0;
            rd_vld_q     <= 1'b0;
            loaded_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= 3'b000;
            status_err_q <= 1'b0;
            buf_ren_q    <= 1'b0;
            buf_addr_q   <= '0;
            dat_out_q    <= 1'b1;
            dat_oe_q     <= 1'b0;
`ifdef SD_BLOCK_TX_CRC_STATUS_EN
            stat_sr_q    <= 3'b000;
`endif
        end else begin
            buf_ren_q <= 1'b0;
            done_q    <= 1'b0;
            rd_vld_q  <= buf_ren_q;
            // Every read after the first lands in the prefetch register.
            if (rd_vld_q && loaded_q) begin
                next_q <= buf_rdata;
            end
            if (abort) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                dat_oe_q  <= 1'b0;
                dat_out_q <= 1'b1;
                rd_vld_q  <= 1'b0;
                loaded_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            buf_addr_q   <= start_addr;
                            buf_ren_q    <= 1'b1;
                            rd_cnt_q     <= RC_W'(1);
                            loaded_q     <= 1'b0;
                            status_q     <= 3'b000;
                            status_err_q <= 1'b0;
                            busy_q       <= 1'b1;
                            state_q      <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (rd_vld_q && !loaded_q) begin
                            shift_q  <= tx_byte_order(buf_rdata);
                            loaded_q <= 1'b1;
                            if (rd_cnt_q < RC_W'(BLOCK_WORDS)) begin
                                buf_ren_q  <= 1'b1;
                                buf_addr_q <= buf_addr_q + ADDR_WIDTH'(1);
                                rd_cnt_q   <= rd_cnt_q + RC_W'(1);
                            end
                        end else if (loaded_q && tick) begin
                            state_q <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (tick) begin
                            dat_oe_q  <= 1'b1;
                            dat_out_q <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (tick) begin
                            dat_out_q <= shift_q[31];
                            shift_q   <= {shift_q[30:0], 1'b0};
                            cnt_q     <= cnt_q + CNT_W'(1);
                            // Word boundary: swap in the prefetched word and request the one after it.
                            if (cnt_q[4:0] == 5'd31) begin
                                shift_q <= tx_byte_order(next_q);
                                if (rd_cnt_q < RC_W'(BLOCK_WORDS)) begin
                                    buf_ren_q  <= 1'b1;
                                    buf_addr_q <= buf_addr_q + ADDR_WIDTH'(1);
                                    rd_cnt_q   <= rd_cnt_q + RC_W'(1);
                                end
                            end
                            if (cnt_q == CNT_W'(TX_BITS - 1)) begin
                                cnt_q   <= '0;
                                state_q <= ST_CRC;
                            end
                        end
                    end
                    ST_CRC: begin
                        if (tick) begin
                            dat_out_q <= crc_w[crc_idx_c];
                            cnt_q     <= cnt_q + CNT_W'(1);
                            if (cnt_q[3:0] == 4'd15) begin
                                cnt_q   <= '0;
                                state_q <= ST_END;
                            end
                        end
                    end
                    ST_END: begin
                        if (tick) begin
                            if (!cnt_q[0]) begin
                                dat_out_q <= 1'b1;
                                cnt_q     <= CNT_W'(1);
                            end else begin
                                dat_oe_q <= 1'b0;
                                cnt_q    <= '0;
`ifdef SD_BLOCK_TX_CRC_STATUS_EN
                                state_q  <= ST_STAT_WAIT;
`else
                                state_q  <= ST_DONE;
`endif
                            end
                        end
                    end
`ifdef SD_BLOCK_TX_CRC_STATUS_EN
                    ST_STAT_WAIT: begin
                        if (tick && !dat_in) begin
                            cnt_q   <= '0;
                            state_q <= ST_STAT;
                        end
                    end
                    ST_STAT: begin
                        // Three token bits, then the token end bit.
                        if (tick) begin
                            if (cnt_q[1:0] != 2'd3) begin
                                stat_sr_q <= {stat_sr_q[1:0], dat_in};
                                cnt_q     <= cnt_q + CNT_W'(1);
                            end else begin
                                cnt_q   <= '0;
                                state_q <= ST_BUSY;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (tick && dat_in) begin
                            state_q <= ST_DONE;
                        end
                    end
`endif
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
`ifdef SD_BLOCK_TX_CRC_STATUS_EN
                        status_q     <= stat_sr_q;
                        status_err_q <= (stat_sr_q != STATUS_OK);
`else
                        status_q     <= STATUS_OK;
                        status_err_q <= 1'b0;
`endif
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign status     = status_q;
    assign status_err = status_err_q;
    assign buf_ren    = buf_ren_q;
    assign buf_addr   = buf_addr_q;
    assign dat_out    = dat_out_q;
    assign dat_oe     = dat_oe_q;

endmodule
